// File: rtl/stopwatch_lap_core.sv
// Stopwatch core with count-up / countdown timekeeping and a lap FIFO.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   i_runstop      single-cycle run/stop toggle
//   i_clear        single-cycle clear (time, divider, lap FIFO, overflow flag)
//   i_lap          single-cycle lap capture (pushes the current time)
//   i_lap_rd       single-cycle lap FIFO pop
//   i_mode_down    direction level, latched when a run starts (1 = countdown)
//   i_load         single-cycle preload strobe (ignored while running)
//   i_load_time    preload value {hour, min, sec, msec} in bits [23:0]
//   msec/sec/min/hour  current time
//   o_running      high while in RUN
//   o_done         one-cycle pulse when a countdown reaches zero
//   o_lap_data     lap FIFO head (first-word fall-through, zero when empty)
//   o_lap_valid    lap FIFO not empty
//   o_lap_full     lap FIFO full
//   o_lap_ovf      sticky flag: a lap was dropped because the FIFO was full
//
// State table
//   STOP | time frozen, divider holds; waiting for run, load or clear
//   RUN  | divider counting, time advances once per tick
//   DONE | countdown reached zero; only clear or load leave this state
//
// The time packing occupies bits [23:0]; bits [25:24] are ignored on load
// and always read back as zero on o_lap_data.

module stopwatch_lap_core #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_runstop,
    input  logic        i_clear,
    input  logic        i_lap,
    input  logic        i_lap_rd,
    input  logic        i_mode_down,
    input  logic        i_load,
    input  logic [25:0] i_load_time,
    output logic [6:0]  msec,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [4:0]  hour,
    output logic        o_running,
    output logic        o_done,
    output logic [25:0] o_lap_data,
    output logic        o_lap_valid,
    output logic        o_lap_full,
    output logic        o_lap_ovf
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(LAP_DEPTH);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(LAP_DEPTH);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          dir_down, dir_nxt;
    logic [DW-1:0] div_cnt, div_nxt;
    logic          tick;
    logic          load_ok;
    logic          time_zero;
    logic          dn_hits_zero;
    logic [25:0]   cur_time;

    logic [6:0]    ms_nxt;
    logic [5:0]    s_nxt;
    logic [5:0]    mi_nxt;
    logic [4:0]    h_nxt;
    logic          running_nxt;
    logic          done_nxt;

    logic [1:0]    unused_load_hi;

    assign unused_load_hi = i_load_time[25:24];
    assign cur_time       = {2'b00, hour, min, sec, msec};
    assign time_zero      = (hour == 5'd0) && (min == 6'd0) && (sec == 6'd0) && (msec == 7'd0);
    // A countdown tick from 00:00:00.01 is the one that lands on zero.
    assign dn_hits_zero   = (hour == 5'd0) && (min == 6'd0) && (sec == 6'd0) && (msec == 7'd1);
    assign load_ok        = i_load && !i_clear && (state != ST_RUN);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_STOP;
            dir_down  <= 1'b0;
            div_cnt   <= '0;
            msec      <= 7'd0;
            sec       <= 6'd0;
            min       <= 6'd0;
            hour      <= 5'd0;
            o_running <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir_down  <= dir_nxt;
            div_cnt   <= div_nxt;
            msec      <= ms_nxt;
            sec       <= s_nxt;
            min       <= mi_nxt;
            hour      <= h_nxt;
            o_running <= running_nxt;
            o_done    <= done_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_down;
        div_nxt   = div_cnt;
        tick      = 1'b0;
        if (i_clear) begin
            state_nxt = ST_STOP;
            div_nxt   = '0;
        end else if (load_ok) begin
            state_nxt = ST_STOP;
            div_nxt   = '0;
        end else if (i_runstop && (state == ST_STOP)) begin
            // Starting a countdown from zero would finish instantly; ignore it.
            if (!(i_mode_down && time_zero)) begin
                state_nxt = ST_RUN;
                dir_nxt   = i_mode_down;
            end
        end else if (i_runstop && (state == ST_RUN)) begin
            // Divider is left untouched so the partial tick survives a pause.
            state_nxt = ST_STOP;
        end else if (state == ST_RUN) begin
            if (div_cnt == DIV_LAST) begin
                div_nxt = '0;
                tick    = 1'b1;
            end else begin
                div_nxt = div_cnt + DIV_ONE;
            end
            if (tick && dir_down && dn_hits_zero) begin
                state_nxt = ST_DONE;
            end
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        ms_nxt      = msec;
        s_nxt       = sec;
        mi_nxt      = min;
        h_nxt       = hour;
        running_nxt = (state_nxt == ST_RUN);
        done_nxt    = 1'b0;
        if (i_clear) begin
            ms_nxt = 7'd0;
            s_nxt  = 6'd0;
            mi_nxt = 6'd0;
            h_nxt  = 5'd0;
        end else if (load_ok) begin
            ms_nxt = (i_load_time[6:0]   > 7'd99) ? 7'd99 : i_load_time[6:0];
            s_nxt  = (i_load_time[12:7]  > 6'd59) ? 6'd59 : i_load_time[12:7];
            mi_nxt = (i_load_time[18:13] > 6'd59) ? 6'd59 : i_load_time[18:13];
            h_nxt  = (i_load_time[23:19] > 5'd23) ? 5'd23 : i_load_time[23:19];
        end else if (tick) begin
            if (!dir_down) begin
                if (msec == 7'd99) begin
                    ms_nxt = 7'd0;
                    if (sec == 6'd59) begin
                        s_nxt = 6'd0;
                        if (min == 6'd59) begin
                            mi_nxt = 6'd0;
                            h_nxt  = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                        end else begin
                            mi_nxt = min + 6'd1;
                        end
                    end else begin
                        s_nxt = sec + 6'd1;
                    end
                end else begin
                    ms_nxt = msec + 7'd1;
                end
            end else begin
                if (msec != 7'd0) begin
                    ms_nxt = msec - 7'd1;
                end else begin
                    ms_nxt = 7'd99;
                    if (sec != 6'd0) begin
                        s_nxt = sec - 6'd1;
                    end else begin
                        s_nxt = 6'd59;
                        if (min != 6'd0) begin
                            mi_nxt = min - 6'd1;
                        end else begin
                            mi_nxt = 6'd59;
                            if (hour != 5'd0) begin
                                h_nxt = hour - 5'd1;
                            end
                        end
                    end
                end
                done_nxt = dn_hits_zero;
            end
        end
    end

    // ---------------- lap FIFO ----------------
    logic [25:0]   mem [LAP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [AW:0]   cnt, cnt_nxt;
    logic          fifo_full;
    logic          push_ok, pop_ok;
    logic          ovf_nxt;
    logic [25:0]   head_nxt;

    assign fifo_full = (cnt == CNT_FULL);
    assign pop_ok    = !i_clear && i_lap_rd && (cnt != '0);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok   = !i_clear && i_lap && (!fifo_full || pop_ok);

    always_comb begin
        wr_nxt  = wr_ptr;
        rd_nxt  = rd_ptr;
        cnt_nxt = cnt;
        ovf_nxt = o_lap_ovf;
        if (i_clear) begin
            wr_nxt  = '0;
            rd_nxt  = '0;
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end else begin
            if (push_ok) wr_nxt = wr_ptr + PTR_ONE;
            if (pop_ok)  rd_nxt = rd_ptr + PTR_ONE;
            if (push_ok && !pop_ok) cnt_nxt = cnt + CNT_ONE;
            else if (pop_ok && !push_ok) cnt_nxt = cnt - CNT_ONE;
            if (i_lap && !push_ok) ovf_nxt = 1'b1;
        end
        // Head is registered; when the new head is the word being written
        // this cycle it has to come straight from the current time.
        if (cnt_nxt == '0) begin
            head_nxt = '0;
        end else if (push_ok && (wr_ptr == rd_nxt)) begin
            head_nxt = cur_time;
        end else begin
            head_nxt = mem[rd_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) mem[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            o_lap_ovf   <= 1'b0;
            o_lap_data  <= '0;
            o_lap_valid <= 1'b0;
            o_lap_full  <= 1'b0;
        end else begin
            if (push_ok) mem[wr_ptr] <= cur_time;
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            cnt         <= cnt_nxt;
            o_lap_ovf   <= ovf_nxt;
            o_lap_data  <= head_nxt;
            o_lap_valid <= (cnt_nxt != '0);
            o_lap_full  <= (cnt_nxt == CNT_FULL);
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
module tb_stopwatch_lap_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_runstop = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_lap = 1'b0;
    logic        i_lap_rd = 1'b0;
    logic        i_mode_down = 1'b0;
    logic        i_load = 1'b0;
    logic [25:0] i_load_time = '0;
    logic [6:0]  msec;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic        o_running;
    logic        o_done;
    logic [25:0] o_lap_data;
    logic        o_lap_valid;
    logic        o_lap_full;
    logic        o_lap_ovf;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [25:0] sb[$];
    logic        ovf_exp;
    int          n;

    stopwatch_lap_core #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .LAP_DEPTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_runstop   (i_runstop),
        .i_clear     (i_clear),
        .i_lap       (i_lap),
        .i_lap_rd    (i_lap_rd),
        .i_mode_down (i_mode_down),
        .i_load      (i_load),
        .i_load_time (i_load_time),
        .msec        (msec),
        .sec         (sec),
        .min         (min),
        .hour        (hour),
        .o_running   (o_running),
        .o_done      (o_done),
        .o_lap_data  (o_lap_data),
        .o_lap_valid (o_lap_valid),
        .o_lap_full  (o_lap_full),
        .o_lap_ovf   (o_lap_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] tpk(input int h, input int m, input int s, input int ms);
        return {2'b00, 5'(h), 6'(m), 6'(s), 7'(ms)};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [25:0] now_t();
        return {2'b00, hour, min, sec, msec};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset values
        #1;
        check("rst_time", 32'(now_t()), 32'(tpk(0, 0, 0, 0)));
        check("rst_running", 32'(o_running), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_lap_valid", 32'(o_lap_valid), 0);
        check("rst_lap_data", 32'(o_lap_data), 0);
        check("rst_lap_full", 32'(o_lap_full), 0);
        check("rst_lap_ovf", 32'(o_lap_ovf), 0);
        cyc();
        rst = 1'b1;

        // count up one second
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (999) cyc();
        check("up_999", 32'(now_t()), 32'(tpk(0, 0, 0, 99)));
        cyc();
        check("up_1s", 32'(now_t()), 32'(tpk(0, 0, 1, 0)));
        check("up_running", 32'(o_running), 1);

        // stop, clamped load, wrap at midnight
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        check("stop_running", 32'(o_running), 0);
        check("stop_hold", 32'(now_t()), 32'(tpk(0, 0, 1, 0)));
        i_load = 1'b1; i_load_time = tpk(31, 63, 63, 127); cyc(); i_load = 1'b0;
        check("load_clamp", 32'(now_t()), 32'(tpk(23, 59, 59, 99)));
        i_load = 1'b1; i_load_time = tpk(23, 59, 59, 98); cyc(); i_load = 1'b0;
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (10) cyc();
        check("wrap_tick1", 32'(now_t()), 32'(tpk(23, 59, 59, 99)));
        repeat (10) cyc();
        check("wrap_tick2", 32'(now_t()), 32'(tpk(0, 0, 0, 0)));
        check("wrap_running", 32'(o_running), 1);

        // countdown to done
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        i_clear = 1'b1; cyc(); i_clear = 1'b0;
        i_mode_down = 1'b1;
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        check("dn_zero_ignored", 32'(o_running), 0);
        i_load = 1'b1; i_load_time = tpk(0, 0, 0, 2); cyc(); i_load = 1'b0;
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (9) cyc();
        check("dn_pre_tick", 32'(now_t()), 32'(tpk(0, 0, 0, 2)));
        cyc();
        check("dn_tick1", 32'(now_t()), 32'(tpk(0, 0, 0, 1)));
        repeat (9) cyc();
        check("dn_no_early_done", 32'(o_done), 0);
        cyc();
        check("dn_tick2", 32'(now_t()), 32'(tpk(0, 0, 0, 0)));
        check("dn_done_pulse", 32'(o_done), 1);
        check("dn_done_state", 32'(o_running), 0);
        cyc();
        check("dn_done_once", 32'(o_done), 0);
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (12) cyc();
        check("done_runstop_ign", 32'(o_running), 0);
        check("done_time_zero", 32'(now_t()), 32'(tpk(0, 0, 0, 0)));

        // five laps into a four-deep FIFO
        i_mode_down = 1'b0;
        i_clear = 1'b1; cyc(); i_clear = 1'b0;
        sb.delete(); ovf_exp = 1'b0;
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (10) cyc();
        for (int k = 1; k <= 5; k++) begin
            i_lap = 1'b1;
            if (sb.size() < 4) sb.push_back(tpk(0, 0, 0, k));
            else ovf_exp = 1'b1;
            cyc();
            i_lap = 1'b0;
            repeat (9) cyc();
        end
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        check("lap_full", 32'(o_lap_full), 1);
        check("lap_ovf", 32'(o_lap_ovf), 32'(ovf_exp));
        check("lap_head", 32'(o_lap_data), 32'(sb[0]));
        for (int k = 0; k < 4; k++) begin
            check("lap_pop", 32'(o_lap_data), 32'(sb.pop_front()));
            i_lap_rd = 1'b1; cyc(); i_lap_rd = 1'b0;
        end
        check("lap_empty_valid", 32'(o_lap_valid), 0);
        check("lap_empty_data", 32'(o_lap_data), 0);
        check("lap_ovf_sticky", 32'(o_lap_ovf), 1);
        i_lap_rd = 1'b1; cyc(); i_lap_rd = 1'b0;
        check("lap_rd_empty", 32'(o_lap_valid), 0);

        // push+pop on empty and on full
        i_clear = 1'b1; cyc(); i_clear = 1'b0;
        sb.delete();
        check("clr_ovf", 32'(o_lap_ovf), 0);
        i_load = 1'b1; i_load_time = tpk(1, 11, 21, 31); cyc(); i_load = 1'b0;
        i_lap = 1'b1; i_lap_rd = 1'b1; sb.push_back(tpk(1, 11, 21, 31));
        cyc(); i_lap = 1'b0; i_lap_rd = 1'b0;
        check("pp_empty_valid", 32'(o_lap_valid), 1);
        check("pp_empty_head", 32'(o_lap_data), 32'(sb[0]));
        for (int k = 2; k <= 4; k++) begin
            i_load = 1'b1; i_load_time = tpk(k, 10 + k, 20 + k, 30 + k); cyc(); i_load = 1'b0;
            i_lap = 1'b1; sb.push_back(tpk(k, 10 + k, 20 + k, 30 + k)); cyc(); i_lap = 1'b0;
        end
        check("pp_fill_full", 32'(o_lap_full), 1);
        i_load = 1'b1; i_load_time = tpk(5, 15, 25, 35); cyc(); i_load = 1'b0;
        i_lap = 1'b1; i_lap_rd = 1'b1;
        sb.push_back(tpk(5, 15, 25, 35)); void'(sb.pop_front());
        cyc(); i_lap = 1'b0; i_lap_rd = 1'b0;
        check("pp_full_full", 32'(o_lap_full), 1);
        check("pp_full_ovf", 32'(o_lap_ovf), 0);
        for (int k = 0; k < 4; k++) begin
            check("pp_pop", 32'(o_lap_data), 32'(sb.pop_front()));
            i_lap_rd = 1'b1; cyc(); i_lap_rd = 1'b0;
        end
        i_lap = 1'b1; cyc(); i_lap = 1'b0;
        i_clear = 1'b1; i_lap = 1'b1; cyc(); i_clear = 1'b0; i_lap = 1'b0;
        check("clr_lap_empty", 32'(o_lap_valid), 0);

        // pause keeps the partial tick; direction latched at start
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (5) cyc();
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        check("pause_stopped", 32'(o_running), 0);
        repeat (20) cyc();
        check("pause_hold", 32'(msec), 0);
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        i_mode_down = 1'b1;
        n = 0;
        while (msec == 7'd0 && n < 30) begin
            cyc();
            n++;
        end
        check("resume_latency", 32'(n), 5);
        check("resume_dir_up", 32'(msec), 1);

        // clear + load + runstop together while running, FIFO overflowed
        i_lap = 1'b1; repeat (5) cyc(); i_lap = 1'b0;
        check("pre_clr_ovf", 32'(o_lap_ovf), 1);
        i_clear = 1'b1; i_load = 1'b1; i_runstop = 1'b1; i_load_time = tpk(3, 3, 3, 3);
        cyc();
        i_clear = 1'b0; i_load = 1'b0; i_runstop = 1'b0;
        check("cmb_time", 32'(now_t()), 32'(tpk(0, 0, 0, 0)));
        check("cmb_running", 32'(o_running), 0);
        check("cmb_valid", 32'(o_lap_valid), 0);
        check("cmb_full", 32'(o_lap_full), 0);
        check("cmb_ovf", 32'(o_lap_ovf), 0);
        repeat (20) cyc();
        check("cmb_stays_stop", 32'(msec), 0);

        // asynchronous reset during RUN
        i_mode_down = 1'b0;
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (25) cyc();
        check("pre_rst_time", 32'(msec), 2);
        #3 rst = 1'b0;
        #1;
        check("arst_running", 32'(o_running), 0);
        check("arst_time", 32'(now_t()), 32'(tpk(0, 0, 0, 0)));
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        check("post_rst_stop", 32'(o_running), 0);
        i_runstop = 1'b1; cyc(); i_runstop = 1'b0;
        repeat (10) cyc();
        check("post_rst_tick", 32'(now_t()), 32'(tpk(0, 0, 0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
